adc_capture_wr_ctrl: RTL and testbench
======================================

Name: adc_capture_wr_ctrl

Overview:
Capture write controller directly upstream of the packet control / fast-read stage. On a capture start or capture again command it writes one full buffer of ADC samples, or a self-test ramp, into the capture memory. It then holds the buffer until the read side reports completion, and exposes the status the register file and the read logic consume.

Parameters:
DATA_W, 18, sample width; matches the ADC_DATA pad bus.
ADDR_W, 12, capture memory address width.
DEPTH, 4096, samples per capture; must satisfy 2 <= DEPTH <= 2**ADDR_W.
DROP_W, 16, width of the dropped-sample counter.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
capture_start  in  1  single-cycle pulse from the register file.
capture_again  in  1  single-cycle pulse from the register file; re-capture without a full restart.
self_test_mode  in  1  1 = write the internal ramp instead of adc_data.
adc_data  in  DATA_W  ADC sample.
adc_valid  in  1  adc_data qualifier.
rd_done  in  1  single-cycle pulse from the fast-read logic; buffer fully consumed.
mem_wen  out  1  memory write enable.
mem_waddr  out  ADDR_W  memory write address.
mem_wdata  out  DATA_W  memory write data.
buf_ready  out  1  level; buffer full and valid for reading.
capture_busy  out  1  level; high in FILL.
capture_done  out  1  one-cycle pulse on the last write.
drop_cnt  out  DROP_W  saturating count of valid samples discarded while the buffer is held.

Behaviour:
- Reset: all outputs 0; state IDLE; ramp counter 0; write pointer 0.
- States: IDLE, FILL, HOLD.
- IDLE:
  - capture_start or capture_again -> FILL next cycle.
  - Pointer cleared to 0; ramp cleared to 0.
  - drop_cnt cleared on capture_start only.
- FILL (capture_busy=1):
  - Normal mode: each cycle with adc_valid=1 gives mem_wen=1, mem_waddr=ptr, mem_wdata=adc_data, all registered. Latency is one cycle from the input sample to the write.
  - self_test_mode=1: a write every cycle, ignoring adc_valid; mem_wdata = ramp; ramp increments by 1 and wraps modulo 2**DATA_W.
  - self_test_mode is sampled on entry to FILL and held for the whole capture.
  - ptr increments after each write.
  - On the write at ptr = DEPTH-1: capture_done pulses in the same cycle as that mem_wen, then the block enters HOLD.
- HOLD (buf_ready=1):
  - No writes.
  - Each adc_valid=1 cycle increments drop_cnt, which saturates at all-ones (no drops counted in self-test).
  - rd_done -> IDLE.
  - capture_again -> FILL directly: ptr=0, ramp=0, drop_cnt kept.
  - capture_start -> FILL: ptr=0, ramp=0, drop_cnt cleared.
  - Start/again take priority over rd_done in the same cycle.
- FILL, simultaneous events:
  - capture_start or capture_again aborts and restarts: ptr=0, ramp=0, no capture_done; start also clears drop_cnt.
  - rd_done is ignored.
- IDLE: capture_start and capture_again in the same cycle are treated as capture_start.
- buf_ready falls in the cycle the block leaves HOLD.
- rst asserted mid-FILL: mem_wen drops immediately (asynchronous); no capture_done.
- The write address never exceeds DEPTH-1; no wrap within a capture.

Test Plan:
1. Self-test, DEPTH=16, capture_start pulse at cycle 5 -> 16 consecutive writes, addr 0..15, data 0..15; capture_done coincides with the addr-15 write; buf_ready=1 afterwards.
2. Normal mode, adc_valid toggling 1,0,1,0 with adc_data=0x3FFFF,0x00001,... -> writes only on valid cycles, one-cycle latency, addr increments by 1 per write, 2*DEPTH-1 cycles to done.
3. HOLD with adc_valid held high for 70000 cycles, DROP_W=16 -> drop_cnt saturates at 0xFFFF; then rd_done -> IDLE, buf_ready=0.
4. HOLD, capture_again pulse -> refill from addr 0 with the ramp restarted at 0, drop_cnt retained; repeated twice to mirror the start, again, again sequence.
5. capture_start at ptr=7 during FILL -> next write at addr 0; no capture_done until a full DEPTH-write run completes.
6. rst pulse at ptr=5 -> all outputs 0 asynchronously; after release no writes until a new capture_start.

Source files
------------

// File: rtl/adc_capture_wr_ctrl.sv
// Capture write controller: fills one buffer of ADC samples (or a self-test
// ramp) into capture memory, holds it until the read side is done, and counts
// samples dropped while the buffer is held.
module adc_capture_wr_ctrl #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_start,
  input  logic              capture_again,
  input  logic              self_test_mode,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              rd_done,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              buf_ready,
  output logic              capture_busy,
  output logic              capture_done,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   ramp_q, ramp_d;
  logic                st_q, st_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                restart;

  assign restart = capture_start | capture_again;

  // Next-state and registered-output computation; every write and status
  // output is produced one cycle after the sample that causes it.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ramp_d  = ramp_q;
    st_d    = st_q;
    drop_d  = drop_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        ptr_d  = '0;
        ramp_d = '0;
        if (restart) begin
          state_d = FILL;
          st_d    = self_test_mode;
        end
        if (capture_start) drop_d = '0;
      end
      FILL: begin
        if (restart) begin
          // Abort the partial capture and start over; no write this cycle.
          ptr_d  = '0;
          ramp_d = '0;
          st_d   = self_test_mode;
          if (capture_start) drop_d = '0;
        end else if (st_q || adc_valid) begin
          wen_d   = 1'b1;
          waddr_d = ptr_q;
          wdata_d = st_q ? ramp_q : adc_data;
          if (st_q) ramp_d = ramp_q + 1'b1;
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == LAST) begin
            done_d  = 1'b1;
            ptr_d   = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (adc_valid && !st_q && (drop_q != '1)) drop_d = drop_q + 1'b1;
        if (restart) begin
          state_d = FILL;
          ptr_d   = '0;
          ramp_d  = '0;
          st_d    = self_test_mode;
          if (capture_start) drop_d = '0;
        end else if (rd_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears the write strobe immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ramp_q  <= '0;
      st_q    <= 1'b0;
      drop_q  <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ramp_q  <= ramp_d;
      st_q    <= st_d;
      drop_q  <= drop_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign mem_wen      = wen_q;
  assign mem_waddr    = waddr_q;
  assign mem_wdata    = wdata_q;
  assign capture_done = done_q;
  assign buf_ready    = (state_q == HOLD);
  assign capture_busy = (state_q == FILL);
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_adc_capture_wr_ctrl.sv
// Directed bench for adc_capture_wr_ctrl with DEPTH=16.
module tb_adc_capture_wr_ctrl;
  localparam int DATA_W = 18;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 16;
  localparam int DROP_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              capture_start = 1'b0, capture_again = 1'b0;
  logic              self_test_mode = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_valid = 1'b0, rd_done = 1'b0;
  logic              mem_wen, buf_ready, capture_busy, capture_done;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DROP_W-1:0] drop_cnt;

  int n_run = 0, n_fail = 0;

  adc_capture_wr_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .capture_start(capture_start), .capture_again(capture_again),
    .self_test_mode(self_test_mode), .adc_data(adc_data), .adc_valid(adc_valid),
    .rd_done(rd_done), .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .buf_ready(buf_ready), .capture_busy(capture_busy), .capture_done(capture_done),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are looked at 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse a command for one cycle, then let the edge sample it.
  task automatic pulse_start(input logic st);
    self_test_mode = st;
    capture_start  = 1'b1;
    step();
    capture_start  = 1'b0;
  endtask

  task automatic pulse_again(input logic st);
    self_test_mode = st;
    capture_again  = 1'b1;
    step();
    capture_again  = 1'b0;
  endtask

  // Expect DEPTH self-test ramp writes starting right away.
  task automatic ramp_fill(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk({tag, "_wen"},   32'(mem_wen), 32'd1);
      chk({tag, "_addr"},  32'(mem_waddr), 32'(i));
      chk({tag, "_data"},  32'(mem_wdata), 32'(i));
      chk({tag, "_done"},  32'(capture_done), 32'(i == DEPTH - 1));
    end
    chk({tag, "_ready"}, 32'(buf_ready), 32'd1);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    logic v;

    // Reset state
    step(); step();
    chk("rst_wen", 32'(mem_wen), 32'd0);
    chk("rst_ready", 32'(buf_ready), 32'd0);
    chk("rst_busy", 32'(capture_busy), 32'd0);
    chk("rst_done", 32'(capture_done), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_addr", 32'(mem_waddr), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // 1: self-test capture
    pulse_start(1'b1);
    chk("t1_busy", 32'(capture_busy), 32'd1);
    ramp_fill("t1");
    step();
    chk("t1_idle_wen", 32'(mem_wen), 32'd0);
    chk("t1_idle_done", 32'(capture_done), 32'd0);
    adc_valid = 1'b1;
    step(); step(); step();
    adc_valid = 1'b0;
    chk("t1_no_drop_selftest", 32'(drop_cnt), 32'd0);
    rd_done = 1'b1; step(); rd_done = 1'b0;
    chk("t1_rd_ready", 32'(buf_ready), 32'd0);

    // 2: normal mode, valid alternating; write index = k/2
    pulse_start(1'b0);
    for (int k = 0; k < 2 * DEPTH; k++) begin
      v = (k % 2 == 0);
      d = (k == 0) ? 18'h3FFFF : DATA_W'(k);
      adc_valid = v;
      adc_data  = d;
      step();
      chk("t2_wen", 32'(mem_wen), 32'(v));
      if (v) begin
        chk("t2_addr", 32'(mem_waddr), 32'(k / 2));
        chk("t2_data", 32'(mem_wdata), 32'(d));
      end
      chk("t2_done", 32'(capture_done), 32'(k == 2 * DEPTH - 2));
    end
    chk("t2_ready", 32'(buf_ready), 32'd1);
    adc_valid = 1'b1;
    step(); step(); step();
    adc_valid = 1'b0;
    step();
    chk("t2_drop3", 32'(drop_cnt), 32'd3);
    chk("t2_hold_wen", 32'(mem_wen), 32'd0);

    // 4: capture_again twice from HOLD; drops kept
    pulse_again(1'b1);
    chk("t4a_drop", 32'(drop_cnt), 32'd3);
    ramp_fill("t4a");
    pulse_again(1'b1);
    ramp_fill("t4b");
    chk("t4b_drop", 32'(drop_cnt), 32'd3);

    // 3: normal refill, then hold with valid high until saturation
    adc_valid = 1'b1;
    adc_data  = 18'h00055;
    pulse_again(1'b0);
    for (int i = 0; i < 70000; i++) step();
    chk("t3_sat", 32'(drop_cnt), 32'hFFFF);
    chk("t3_ready", 32'(buf_ready), 32'd1);
    adc_valid = 1'b0;
    rd_done = 1'b1; step(); rd_done = 1'b0;
    chk("t3_rd_ready", 32'(buf_ready), 32'd0);
    chk("t3_idle_drop", 32'(drop_cnt), 32'hFFFF);

    // 5: restart with capture_start after 7 writes
    pulse_start(1'b1);
    chk("t5_drop_clr", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 7; i++) step();
    chk("t5_addr6", 32'(mem_waddr), 32'd6);
    capture_start = 1'b1; step(); capture_start = 1'b0;
    chk("t5_abort_wen", 32'(mem_wen), 32'd0);
    chk("t5_abort_done", 32'(capture_done), 32'd0);
    ramp_fill("t5");

    // 6: asynchronous reset mid-fill
    rd_done = 1'b1; step(); rd_done = 1'b0;
    pulse_start(1'b1);
    for (int i = 0; i < 5; i++) step();
    chk("t6_pre_wen", 32'(mem_wen), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_wen", 32'(mem_wen), 32'd0);
    chk("t6_async_busy", 32'(capture_busy), 32'd0);
    chk("t6_async_addr", 32'(mem_waddr), 32'd0);
    chk("t6_async_data", 32'(mem_wdata), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t6_idle_wen", 32'(mem_wen), 32'd0);
      chk("t6_idle_done", 32'(capture_done), 32'd0);
    end
    pulse_start(1'b1);
    ramp_fill("t6");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
